// File: rtl/ext_unit_pipe.sv
// Run-time selectable sign/zero extender with optional left shift, wrapped in a
// two-stage valid/ready pipeline that carries an opaque tag alongside each beat.
module ext_unit_pipe #(
   parameter int IN_W  = 22,
   parameter int OUT_W = 32,
   parameter int W0    = 18,
   parameter int W1    = 22,
   parameter int W2    = 16,
   parameter int W3    = 8,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_field,
   input  logic [1:0]       in_mode,
   input  logic             in_signed,
   input  logic [1:0]       in_shift,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);

   // Masks rather than variable bit-selects keep the width choice purely arithmetic.
   function automatic logic [OUT_W-1:0] extend_field(
      input logic [IN_W-1:0] field,
      input logic [1:0]      mode,
      input logic            sgn
   );
      logic [OUT_W-1:0] wide;
      logic [OUT_W-1:0] keep_mask;
      logic [OUT_W-1:0] msb_mask;
      logic             fill;
      int               w;
      case (mode)
         2'd0:    w = W0;
         2'd1:    w = W1;
         2'd2:    w = W2;
         default: w = W3;
      endcase
      wide      = {{(OUT_W-IN_W){1'b0}}, field};
      keep_mask = ~({OUT_W{1'b1}} << w);
      msb_mask  = {{(OUT_W-1){1'b0}}, 1'b1} << (w - 1);
      fill      = sgn & (|(wide & msb_mask));
      return (wide & keep_mask) | ({OUT_W{fill}} & ~keep_mask);
   endfunction

   logic             s1_valid_q, s1_valid_d;
   logic [OUT_W-1:0] s1_ext_q,   s1_ext_d;
   logic [1:0]       s1_shift_q, s1_shift_d;
   logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
   logic             s2_valid_q, s2_valid_d;
   logic [OUT_W-1:0] s2_data_q,  s2_data_d;
   logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

   logic s1_load;
   logic s2_load;

   assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
   assign in_ready = !s1_valid_q || s2_load;
   assign s1_load  = in_valid && in_ready;

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_tag   = s2_tag_q;

   // Next-state for both stages; flush only clears valids, data is don't-care.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_ext_d   = s1_ext_q;
      s1_shift_d = s1_shift_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_tag_d   = s2_tag_q;

      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_load || (s1_valid_q && !s2_load);
         s2_valid_d = s2_load || (s2_valid_q && !out_ready);
      end

      if (s1_load) begin
         s1_ext_d   = extend_field(in_field, in_mode, in_signed);
         s1_shift_d = in_shift;
         s1_tag_d   = in_tag;
      end else begin
         s1_ext_d   = s1_ext_q;
         s1_shift_d = s1_shift_q;
         s1_tag_d   = s1_tag_q;
      end

      if (s2_load) begin
         s2_data_d = s1_ext_q << s1_shift_q;
         s2_tag_d  = s1_tag_q;
      end else begin
         s2_data_d = s2_data_q;
         s2_tag_d  = s2_tag_q;
      end
   end

   // Pipeline registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_ext_q   <= {OUT_W{1'b0}};
         s1_shift_q <= 2'd0;
         s1_tag_q   <= {TAG_W{1'b0}};
         s2_valid_q <= 1'b0;
         s2_data_q  <= {OUT_W{1'b0}};
         s2_tag_q   <= {TAG_W{1'b0}};
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_ext_q   <= s1_ext_d;
         s1_shift_q <= s1_shift_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

endmodule
